lu_ctrl: RTL
============

Name: lu_ctrl

Overview:
Sequencing front-end for the 4-bit logic unit. It accepts one command (opcode, two operands, repeat count) over a valid/ready handshake and drives the logic unit's a/b/sel inputs from registers. It captures the unit's combinational result each cycle and feeds it back as operand a for repeated operations, such as multi-bit shifts or chained NOT/XOR. It presents the final result downstream over a valid/ready handshake.

Parameters:
W, 4, operand/result width; must match logic unit width.
REP_W, 3, width of repeat counter; a command allows up to 2^REP_W - 1 extra iterations.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command.
cmd_op  input  3  logic-unit opcode: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOT a, 5 a<<1, 6 a>>1, 7 illegal.
cmd_a  input  W  operand a.
cmd_b  input  W  operand b.
cmd_rep  input  REP_W  extra iterations; total LU evaluations = cmd_rep+1.
lu_a  output  W  to logic unit a.
lu_b  output  W  to logic unit b.
lu_sel  output  3  to logic unit sel.
lu_out  input  W  logic unit result (combinational from lu_a/lu_b/lu_sel).
res_valid  output  1  result available.
res_ready  input  1  downstream accepts result.
res_data  output  W  final result.
res_err  output  1  command had illegal opcode.

Behaviour:
- State machine IDLE, EXEC, DONE. All registers update on the rising edge of clk.
- Reset, taking priority over everything and valid from any state:
  - state=IDLE; a_reg, b_reg, op_reg, cnt, res_data = 0; res_valid=0; res_err=0.
  - lu_a/lu_b/lu_sel therefore read 0.
- Derived outputs:
  - cmd_ready = (state==IDLE).
  - res_valid = (state==DONE).
  - lu_a=a_reg, lu_b=b_reg, lu_sel=op_reg at all times.
- IDLE, on cmd_valid (accept edge):
  - If cmd_op==7: res_data<=0, res_err<=1, go to DONE. No EXEC, and op_reg is left unchanged, so lu_sel never shows 7.
  - Otherwise: a_reg<=cmd_a, b_reg<=cmd_b, op_reg<=cmd_op, cnt<=cmd_rep, res_err<=0, go to EXEC.
- EXEC, each cycle:
  - a_reg<=lu_out.
  - If cnt==0: res_data<=lu_out, go to DONE.
  - Else: cnt<=cnt-1, stay in EXEC.
  - b_reg and op_reg are held throughout.
- DONE:
  - res_data and res_err are held stable while res_valid=1 and res_ready=0.
  - When res_ready=1, the result is consumed on that edge and the block goes to IDLE.
- Latency: res_valid rises cmd_rep+1 cycles after the accept edge (1 cycle for illegal op).
- Throughput: minimum cmd_rep+3 cycles per command. No command overlap; cmd_valid outside IDLE is ignored.
- Width rules:
  - Every value is truncated to W bits.
  - Shift-left drops the MSB and shift-right inserts 0, both as done by the logic unit.
  - Repeated shifts beyond W give 0.
  - cnt is unsigned and never wraps, because exit occurs at 0.
- Simultaneous events:
  - rst together with cmd_valid: reset wins, and the command is not accepted.
  - rst together with a res_ready handshake: reset wins, and the block enters IDLE.
  - Reset mid-EXEC aborts the operation; the next cycle shows IDLE, cmd_ready=1, res_valid=0.

Test Plan:
1. AND: op=0, a=4'hC, b=4'hA, rep=0, res_ready=1 -> one cycle after accept, res_valid=1, res_data=4'h8, res_err=0; lu_sel=0 during EXEC; cmd_ready=1 again the following cycle.
2. Repeated shift-left: op=5, a=4'h1, rep=2 -> lu_a sequence 1,2,4 over three EXEC cycles; res_data=4'h8 three cycles after accept. Then op=5, a=4'h1, rep=4 -> res_data=4'h0.
3. Chained feedback: op=2, a=4'h5, b=4'h3, rep=1 -> 6 then 5, res_data=4'h5. Then op=4, a=4'h3, rep=1 -> res_data=4'h3. Then op=6, a=4'hF, rep=1 -> res_data=4'h3.
4. Illegal opcode: op=7, a=4'hF -> res_valid=1 one cycle after accept, res_err=1, res_data=0, no EXEC cycle, lu_sel unchanged. The next legal command clears res_err.
5. Backpressure: op=1, a=4'h9, b=4'h6, res_ready held 0 for 5 cycles with cmd_valid held 1 -> res_data=4'hF stable, res_valid=1, cmd_ready=0, and no second command accepted. Raising res_ready completes the handshake, returns the block to IDLE, and the pending command is then accepted.
6. Reset mid-operation: op=5, a=4'h1, rep=7; assert rst on the 3rd EXEC cycle -> next cycle state IDLE, cmd_ready=1, res_valid=0, lu_a=lu_b=lu_sel=0. A fresh command then completes normally.

Source files
------------

// File: rtl/lu_ctrl.sv
// Sequencing front-end for the logic unit: accepts one command, iterates the
// unit with its result fed back as operand a, and returns the final result.
module lu_ctrl #(
  parameter int W     = 4,
  parameter int REP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic [REP_W-1:0] cmd_rep,
  output logic [W-1:0]     lu_a,
  output logic [W-1:0]     lu_b,
  output logic [2:0]       lu_sel,
  input  logic [W-1:0]     lu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic             res_err
);

  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [REP_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     res_data_q, res_data_d;
  logic             res_err_q, res_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
    end
  end

  // An illegal opcode skips EXEC entirely and reports straight from DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid) state_d = (cmd_op == OP_ILLEGAL) ? DONE : EXEC;
      EXEC: if (cnt_q == '0) state_d = DONE;
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_ILLEGAL) begin
            res_data_d = '0;
            res_err_d  = 1'b1;
          end else begin
            a_d       = cmd_a;
            b_d       = cmd_b;
            op_d      = cmd_op;
            cnt_d     = cmd_rep;
            res_err_d = 1'b0;
          end
        end
      end
      EXEC: begin
        // The unit's result becomes operand a, so each cycle chains one more step.
        a_d = lu_out;
        if (cnt_q == '0) res_data_d = lu_out;
        else             cnt_d      = cnt_q - REP_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    res_valid = (state_q == DONE);
    lu_a      = a_q;
    lu_b      = b_q;
    lu_sel    = op_q;
    res_data  = res_data_q;
    res_err   = res_err_q;
  end

endmodule
